// File: rtl/am_error_monitor_if.sv
// Operand stream into the error monitor: valid/ready handshake carrying one
// operand pair per transfer.
interface am_error_monitor_if #(
  parameter int W = 8
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;

  modport master (output in_valid, output in_a, output in_b, input  in_ready);
  modport slave  (input  in_valid, input  in_a, input  in_b, output in_ready);
endinterface

// File: rtl/am_error_monitor.sv
// Characterisation harness for an 8x8 approximate multiplier: registers the
// operands, compares the returned product with the exact one, accumulates stats.
module am_error_monitor #(
  parameter int W     = 8,
  parameter int CNT_W = 16,
  parameter int ACC_W = 40
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [CNT_W-1:0]   num_samples,
  am_error_monitor_if.slave  s_if,
  output logic [W-1:0]       mul_a,
  output logic [W-1:0]       mul_b,
  input  logic [2*W-1:0]     mul_p,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   sample_count,
  output logic [CNT_W-1:0]   err_count,
  output logic [2*W-1:0]     max_ed,
  output logic [ACC_W-1:0]   sum_ed,
  output logic [ACC_W-1:0]   bias_sum
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;
  localparam int         PW   = 2 * W;

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] limit_q, limit_d, acc_cnt_q, acc_cnt_d;
  logic [W-1:0]     mul_a_q, mul_a_d, mul_b_q, mul_b_d;
  logic [1:0]       vld_pipe_q, vld_pipe_d;
  logic [PW-1:0]    p_apx_q, p_apx_d, p_ex_q, p_ex_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] sc_q, sc_d, ec_q, ec_d;
  logic [PW-1:0]    max_q, max_d;
  logic [ACC_W-1:0] sum_q, sum_d, bias_q, bias_d;

  logic             ready, accept, last;
  logic [PW-1:0]    ed;
  logic [PW:0]      delta;
  logic [ACC_W:0]   sum_wide, bias_wide;
  logic [ACC_W-1:0] sum_sat, bias_sat;

  assign ready  = (state_q == RUN) && (acc_cnt_q < limit_q);
  assign accept = s_if.in_valid & ready;
  assign last   = vld_pipe_q[1] && ((sc_q + CNT_W'(1)) == limit_q);

  assign ed    = (p_ex_q >= p_apx_q) ? (p_ex_q - p_apx_q) : (p_apx_q - p_ex_q);
  assign delta = {1'b0, p_apx_q} - {1'b0, p_ex_q};

  // One extra bit of headroom exposes the carry / signed overflow to clamp on.
  assign sum_wide  = {1'b0, sum_q} + {{(ACC_W+1-PW){1'b0}}, ed};
  assign bias_wide = {bias_q[ACC_W-1], bias_q} + {{(ACC_W-PW){delta[PW]}}, delta};

  always_comb begin
    sum_sat = sum_wide[ACC_W] ? {ACC_W{1'b1}} : sum_wide[ACC_W-1:0];
    if (bias_wide[ACC_W] != bias_wide[ACC_W-1])
      bias_sat = bias_wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    else
      bias_sat = bias_wide[ACC_W-1:0];
  end

  always_comb begin
    state_d    = state_q;
    limit_d    = limit_q;
    acc_cnt_d  = acc_cnt_q;
    mul_a_d    = mul_a_q;
    mul_b_d    = mul_b_q;
    vld_pipe_d = {vld_pipe_q[0], accept};
    p_apx_d    = mul_p;
    p_ex_d     = PW'(mul_a_q) * PW'(mul_b_q);
    done_d     = 1'b0;
    sc_d       = sc_q;
    ec_d       = ec_q;
    max_d      = max_q;
    sum_d      = sum_q;
    bias_d     = bias_q;

    if (accept) begin
      mul_a_d   = s_if.in_a;
      mul_b_d   = s_if.in_b;
      acc_cnt_d = acc_cnt_q + CNT_W'(1);
    end

    if (vld_pipe_q[1]) begin
      sc_d = sc_q + CNT_W'(1);
      if (ed != '0) ec_d = ec_q + CNT_W'(1);
      if (ed > max_q) max_d = ed;
      sum_d  = sum_sat;
      bias_d = bias_sat;
    end

    case (state_q)
      IDLE: begin
        // done_q high means this is the completion cycle; start is dropped then.
        if (start && !done_q) begin
          sc_d   = '0;
          ec_d   = '0;
          max_d  = '0;
          sum_d  = '0;
          bias_d = '0;
          if (num_samples != '0) begin
            limit_d   = num_samples;
            acc_cnt_d = '0;
            state_d   = RUN;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      default: begin
        if (last) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      limit_q    <= '0;
      acc_cnt_q  <= '0;
      mul_a_q    <= '0;
      mul_b_q    <= '0;
      vld_pipe_q <= '0;
      p_apx_q    <= '0;
      p_ex_q     <= '0;
      done_q     <= 1'b0;
      sc_q       <= '0;
      ec_q       <= '0;
      max_q      <= '0;
      sum_q      <= '0;
      bias_q     <= '0;
    end else begin
      state_q    <= state_d;
      limit_q    <= limit_d;
      acc_cnt_q  <= acc_cnt_d;
      mul_a_q    <= mul_a_d;
      mul_b_q    <= mul_b_d;
      vld_pipe_q <= vld_pipe_d;
      p_apx_q    <= p_apx_d;
      p_ex_q     <= p_ex_d;
      done_q     <= done_d;
      sc_q       <= sc_d;
      ec_q       <= ec_d;
      max_q      <= max_d;
      sum_q      <= sum_d;
      bias_q     <= bias_d;
    end
  end

  assign s_if.in_ready = ready;
  assign mul_a         = mul_a_q;
  assign mul_b         = mul_b_q;
  assign busy          = (state_q == RUN);
  assign done          = done_q;
  assign sample_count  = sc_q;
  assign err_count     = ec_q;
  assign max_ed        = max_q;
  assign sum_ed        = sum_q;
  assign bias_sum      = bias_q;
endmodule

// File: tb/tb_am_error_monitor.sv
// Directed bench: two monitors (ACC_W=40 and ACC_W=17) share one stimulus
// stream; mul_p comes from a selectable stub (exact, zero, exact+3).
module tb_am_error_monitor;
  logic        clk = 1'b0;
  logic        rst_n, start, v;
  logic [15:0] num;
  logic [7:0]  a, b;
  int          mode;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  am_error_monitor_if #(.W(8)) if0 ();
  am_error_monitor_if #(.W(8)) if1 ();
  assign if0.in_valid = v;
  assign if0.in_a     = a;
  assign if0.in_b     = b;
  assign if1.in_valid = v;
  assign if1.in_a     = a;
  assign if1.in_b     = b;

  logic [7:0]  ma0, mb0, ma1, mb1;
  logic [15:0] mp0, mp1, sc0, ec0, sc1, ec1, mx0, mx1;
  logic        busy0, done0, busy1, done1;
  logic [39:0] sum0, bias0;
  logic [16:0] sum1, bias1;

  function automatic logic [15:0] stub(input int m, input logic [7:0] x, input logic [7:0] y);
    logic [15:0] p;
    p = 16'(x) * 16'(y);
    case (m)
      1:       return 16'd0;
      2:       return p + 16'd3;
      default: return p;
    endcase
  endfunction

  assign mp0 = stub(mode, ma0, mb0);
  assign mp1 = stub(mode, ma1, mb1);

  am_error_monitor #(.W(8), .CNT_W(16), .ACC_W(40)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .num_samples(num), .s_if(if0),
    .mul_a(ma0), .mul_b(mb0), .mul_p(mp0), .busy(busy0), .done(done0),
    .sample_count(sc0), .err_count(ec0), .max_ed(mx0), .sum_ed(sum0), .bias_sum(bias0));

  am_error_monitor #(.W(8), .CNT_W(16), .ACC_W(17)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .num_samples(num), .s_if(if1),
    .mul_a(ma1), .mul_b(mb1), .mul_p(mp1), .busy(busy1), .done(done1),
    .sample_count(sc1), .err_count(ec1), .max_ed(mx1), .sum_ed(sum1), .bias_sum(bias1));

  typedef struct {
    int     mode;
    int     n;
    int     a[4];
    int     b[4];
    longint sc, ec, mx, sum, bias, sum17, bias17;
  } vec_t;

  vec_t tbl[4];

  function automatic vec_t mk(input int m, input int n, input int a0, input int b0,
                              input int a1, input int b1, input int a2, input int b2,
                              input int a3, input int b3, input longint sc, input longint ec,
                              input longint mx, input longint sum, input longint bias,
                              input longint sum17, input longint bias17);
    vec_t r;
    r.mode = m; r.n = n;
    r.a[0] = a0; r.b[0] = b0; r.a[1] = a1; r.b[1] = b1;
    r.a[2] = a2; r.b[2] = b2; r.a[3] = a3; r.b[3] = b3;
    r.sc = sc; r.ec = ec; r.mx = mx; r.sum = sum; r.bias = bias;
    r.sum17 = sum17; r.bias17 = bias17;
    return r;
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic run_row(input int idx);
    vec_t r;
    int   lat;
    r    = tbl[idx];
    mode = r.mode;
    @(negedge clk); start = 1'b1; num = 16'(r.n);
    @(negedge clk); start = 1'b0;
    chk($sformatf("row%0d_ready", idx), longint'(if0.in_ready), 1);
    for (int i = 0; i < r.n; i++) begin
      v = 1'b1; a = 8'(r.a[i]); b = 8'(r.b[i]);
      @(negedge clk);
    end
    v = 1'b0;
    lat = 0;
    while (!done0 && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    chk($sformatf("row%0d_done_latency", idx), lat, 2);
    chk($sformatf("row%0d_samples", idx), longint'(sc0), r.sc);
    chk($sformatf("row%0d_errs", idx), longint'(ec0), r.ec);
    chk($sformatf("row%0d_max_ed", idx), longint'(mx0), r.mx);
    chk($sformatf("row%0d_sum_ed", idx), longint'(sum0), r.sum);
    chk($sformatf("row%0d_bias", idx), longint'($signed(bias0)), r.bias);
    chk($sformatf("row%0d_max_ed17", idx), longint'(mx1), r.mx);
    chk($sformatf("row%0d_sum_ed17", idx), longint'(sum1), r.sum17);
    chk($sformatf("row%0d_bias17", idx), longint'($signed(bias1)), r.bias17);
    @(negedge clk);
    chk($sformatf("row%0d_done_width", idx), longint'(done0), 0);
    chk($sformatf("row%0d_busy_after", idx), longint'(busy0), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int dseen;
    tbl[0] = mk(0, 4, 3, 5, 255, 255, 0, 7, 128, 2, 4, 0, 0, 0, 0, 0, 0);
    tbl[1] = mk(1, 2, 10, 10, 255, 255, 0, 0, 0, 0, 2, 2, 65025, 65125, -65125, 65125, -65125);
    tbl[2] = mk(2, 2, 2, 3, 4, 5, 0, 0, 0, 0, 2, 2, 3, 6, 6, 6, 6);
    tbl[3] = mk(1, 3, 255, 255, 255, 255, 255, 255, 0, 0, 3, 3, 65025, 195075, -195075, 131071, -65536);

    rst_n = 1'b0; start = 1'b0; v = 1'b0; num = '0; a = '0; b = '0; mode = 0;
    repeat (2) @(negedge clk);
    chk("reset_ready", longint'(if0.in_ready), 0);
    chk("reset_busy", longint'(busy0), 0);
    chk("reset_done", longint'(done0), 0);
    chk("reset_stats", longint'(sc0) + longint'(ec0) + longint'(mx0) + longint'(sum0) + longint'(bias0), 0);
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) run_row(i);

    // in_valid held for 6 cycles against a limit of 2
    mode = 2; dseen = 0;
    @(negedge clk); start = 1'b1; num = 16'd2;
    @(negedge clk); start = 1'b0;
    for (int k = 0; k < 6; k++) begin
      v = 1'b1; a = 8'd7; b = 8'd9;
      chk($sformatf("stall_ready_%0d", k), longint'(if0.in_ready), (k < 2) ? 1 : 0);
      @(negedge clk);
      if (done0) dseen++;
    end
    v = 1'b0;
    chk("stall_done_count", dseen, 1);
    chk("stall_samples", longint'(sc0), 2);
    chk("stall_sum_ed", longint'(sum0), 6);
    chk("stall_bias", longint'($signed(bias0)), 6);

    // zero-sample run clears the previous statistics
    @(negedge clk); start = 1'b1; num = 16'd0;
    @(negedge clk); start = 1'b0;
    chk("zero_done", longint'(done0), 1);
    chk("zero_busy", longint'(busy0), 0);
    @(negedge clk);
    chk("zero_done_width", longint'(done0), 0);
    chk("zero_busy2", longint'(busy0), 0);
    chk("zero_stats", longint'(sc0) + longint'(ec0) + longint'(mx0) + longint'(sum0) + longint'(bias0), 0);

    // reset at the edge after the 2nd of 4 accepts
    mode = 1;
    @(negedge clk); start = 1'b1; num = 16'd4;
    @(negedge clk); start = 1'b0;
    v = 1'b1; a = 8'd3; b = 8'd5; @(negedge clk);
    a = 8'd6; b = 8'd7;           @(negedge clk);
    v = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_samples", longint'(sc0), 0);
    chk("midrst_stats", longint'(ec0) + longint'(mx0) + longint'(sum0) + longint'(bias0), 0);
    chk("midrst_mul", longint'(ma0) + longint'(mb0), 0);
    chk("midrst_ready", longint'(if0.in_ready), 0);
    chk("midrst_busy", longint'(busy0), 0);
    chk("midrst_done", longint'(done0), 0);
    rst_n = 1'b1;
    dseen = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (done0 || busy0) dseen++;
    end
    chk("midrst_quiet", dseen, 0);
    run_row(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/am_error_monitor.md
Name: am_error_monitor

Overview:
- Sequential characterisation harness wrapped around any combinational unsigned approximate multiplier (8x8 -> 16) in the AM library.
- Upstream of the multiplier: accepts an operand stream through a valid/ready handshake and registers the operands that drive the multiplier.
- Downstream of the multiplier: consumes the approximate product and compares it with an internally computed exact product.
- Accumulates error-distance statistics over a programmed number of samples and reports them at run end.

Parameters:
- W, 8, operand width; product width is 2W.
- CNT_W, 16, width of the sample limit and of the sample/error counters.
- ACC_W, 40, width of the sum_ed and bias_sum accumulators. Must satisfy ACC_W >= 2W+1.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  one-cycle pulse that begins a run. Ignored while busy.
- num_samples  in  CNT_W  number of samples in the run; sampled on start.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block accepts an operand pair this cycle.
- in_a  in  W  operand A.
- in_b  in  W  operand B.
- mul_a  out  W  registered operand A driven to the multiplier.
- mul_b  out  W  registered operand B driven to the multiplier.
- mul_p  in  2W  approximate product returned by the multiplier (combinational from mul_a/mul_b).
- busy  out  1  run in progress.
- done  out  1  one-cycle pulse: statistics are final.
- sample_count  out  CNT_W  samples accumulated.
- err_count  out  CNT_W  samples with nonzero error distance.
- max_ed  out  2W  maximum |exact - approx|.
- sum_ed  out  ACC_W  sum of |exact - approx|, unsigned, saturating.
- bias_sum  out  ACC_W  signed two's-complement sum of (approx - exact), saturating at both rails.

Behaviour:
- Reset (rst_n=0 at a clock edge): every output is 0, state is IDLE, and both pipeline valids are cleared. Reset takes effect mid-run with no completion pulse.
- States:
  - IDLE: in_ready=0, busy=0.
    - start with num_samples != 0: clear all statistics, latch the limit, accepted counter=0, next state RUN.
    - start with num_samples == 0: clear statistics, done=1 for one cycle, stay IDLE.
  - RUN: busy=1. in_ready=1 while accepted < limit, else 0. After the last accept, stay in RUN until the pipeline drains.
- Pipeline (accept at edge E0, i.e. in_valid & in_ready sampled high):
  - E0: mul_a<=in_a, mul_b<=in_b, accepted++, s1_valid<=1. mul_a/mul_b hold until the next accept.
  - E1: p_apx<=mul_p, p_ex<=mul_a*mul_b (exact, 2W bits), s2_valid<=s1_valid.
  - E2 (if s2_valid):
    - ed = |p_ex - p_apx| in 2W bits.
    - sample_count++.
    - err_count++ if ed != 0.
    - max_ed<=max(max_ed, ed).
    - sum_ed<=sat(sum_ed+ed).
    - bias_sum<=sat_signed(bias_sum + (p_apx - p_ex)).
- Latency and throughput: latency is 2 edges from accept to statistics update. Throughput is 1 sample/cycle; back-to-back accepts are fully pipelined.
- Completion: the edge that performs the update with sample_count reaching the limit also:
  - sets done=1 for exactly one cycle;
  - sets busy=0;
  - returns the state to IDLE.
- Statistics hold their values until the next start or reset.
- in_valid while in_ready=0 is ignored; no buffering.
- A start pulse coinciding with the done cycle is ignored.
- Saturation:
  - sum_ed clamps at 2^ACC_W-1.
  - bias_sum clamps at 2^(ACC_W-1)-1 and -2^(ACC_W-1).
  - Counters cannot overflow because the limit is at most 2^CNT_W-1.
- The multiplier path mul_a/mul_b -> mul_p must settle within one clock period. The block adds no pipelining inside it.

Test Plan:
- mul_p tied to an exact-product stub, num_samples=4, operands (3,5),(255,255),(0,7),(128,2) back-to-back -> sample_count=4, err_count=0, max_ed=0, sum_ed=0, bias_sum=0, done pulses 2 cycles after the 4th accept.
- mul_p tied to 0, num_samples=2, operands (10,10),(255,255) -> sum_ed=65125, max_ed=65025, err_count=2, bias_sum=-65125.
- Stub returning exact+3, num_samples=2, in_valid held high for 6 cycles -> exactly 2 accepts, in_ready low from the cycle after the 2nd accept, bias_sum=+6, sum_ed=6.
- start with num_samples=0 -> done high exactly one cycle later for 1 cycle, busy never asserted, all statistics 0.
- rst_n pulled low at the edge after the 2nd of 4 accepts -> all outputs 0 from that edge, in_ready=0, busy=0, no done pulse. A subsequent start runs normally.
- ACC_W=17, mul_p=0, num_samples=3, operands (255,255)x3 -> sum_ed saturates at 131071, bias_sum saturates at -65536, max_ed=65025.
